axis_spi_slave_fifo: RTL

//  SPI slave bridging an external SPI master to AXI-Stream, generalised in word width, SPI mode and buffer depth.
//  SPI pins are oversampled in the axis_aclk domain. TX words (s_axis) are buffered in a FIFO and shifted out on MISO.
//  RX words from MOSI are buffered in a FIFO and presented on m_axis. Sits between the SPI pads and the copter command/telemetry router.

---
 rtl/axis_spi_slave_fifo.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/axis_spi_slave_fifo.sv
// SPI slave with AXI-Stream TX/RX FIFOs; SPI pins are oversampled in the axis_aclk domain.
// Define AXIS_SPI_STATUS_EN to add the overflow/underrun counters and the frame-abort pulse.
module axis_spi_slave_fifo #(
  parameter int                DATA_W        = 8,
  parameter bit                CPOL          = 1'b0,
  parameter bit                CPHA          = 1'b0,
  parameter int                TX_DEPTH      = 4,
  parameter int                RX_DEPTH      = 4,
  parameter int                SYNC_STAGES   = 2,
  parameter logic [DATA_W-1:0] UNDERRUN_FILL = '0
) (
  input  logic              axis_aclk,
  input  logic              axis_areset,
  input  logic              i_spi_clk,
  input  logic              i_spi_cs,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser
`ifdef AXIS_SPI_STATUS_EN
  ,
  output logic [7:0]        o_rx_overflow_cnt,
  output logic [7:0]        o_tx_underrun_cnt,
  output logic              o_frame_abort
`endif
);
  localparam int TXA   = $clog2(TX_DEPTH);
  localparam int RXA   = $clog2(RX_DEPTH);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {WAIT_CS_HIGH, IDLE, LOAD, SHIFT} state_t;

  // CS chain resets low so a frame already in progress keeps us in WAIT_CS_HIGH
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_prev, cs_prev, sclk_s, cs_s, mosi_s;

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= CPOL;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_rise, cs_fall;
  assign lead_edge   = (sclk_prev == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_prev != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_rise     = !cs_prev && cs_s;
  assign cs_fall     = cs_prev && !cs_s;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic               first;
  logic [DATA_W-2:0]  rx_shift;
  logic [DATA_W-1:0]  tx_shift;
  logic               miso;
  logic               word_done, tx_load;

  assign word_done = (state == SHIFT) && !cs_rise && sample_edge
                     && (bit_cnt == CNT_W'(DATA_W-1));
  assign tx_load   = ((state == LOAD) && !cs_rise) || word_done;

  // TX FIFO
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TXA:0]      tx_wr, tx_rd;
  logic              tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_word;

  assign tx_empty      = (tx_wr == tx_rd);
  assign tx_full       = (tx_wr[TXA] != tx_rd[TXA]) && (tx_wr[TXA-1:0] == tx_rd[TXA-1:0]);
  assign s_axis_tready = !axis_areset && !tx_full;
  assign tx_push       = s_axis_tvalid && s_axis_tready;
  assign tx_pop        = tx_load && !tx_empty;
  assign tx_word       = tx_empty ? UNDERRUN_FILL : tx_mem[tx_rd[TXA-1:0]];

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
    end
  end

  always_ff @(posedge axis_aclk)
    if (tx_push) tx_mem[tx_wr[TXA-1:0]] <= s_axis_tdata;

  // RX FIFO, each entry carries its first-word flag alongside the data
  logic [DATA_W:0] rx_mem [RX_DEPTH];
  logic [RXA:0]    rx_wr, rx_rd;
  logic            rx_empty, rx_full, rx_push, rx_pop;
  logic [DATA_W:0] rx_head;

  assign rx_empty      = (rx_wr == rx_rd);
  assign rx_full       = (rx_wr[RXA] != rx_rd[RXA]) && (rx_wr[RXA-1:0] == rx_rd[RXA-1:0]);
  assign rx_push       = word_done && !rx_full;
  assign m_axis_tvalid = !rx_empty;
  assign rx_pop        = m_axis_tvalid && m_axis_tready;
  assign rx_head       = rx_empty ? '0 : rx_mem[rx_rd[RXA-1:0]];
  assign m_axis_tdata  = rx_head[DATA_W-1:0];
  assign m_axis_tuser  = rx_head[DATA_W];

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
    end
  end

  always_ff @(posedge axis_aclk)
    if (rx_push) rx_mem[rx_wr[RXA-1:0]] <= {first, rx_shift, mosi_s};

  // CPHA=0 presents the MSB at load; CPHA=1 waits for the first leading edge
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state    <= WAIT_CS_HIGH;
      bit_cnt  <= '0;
      first    <= 1'b0;
      rx_shift <= '0;
      tx_shift <= '0;
      miso     <= 1'b0;
    end else if (cs_rise) begin
      state   <= IDLE;
      bit_cnt <= '0;
      miso    <= 1'b0;
    end else begin
      case (state)
        WAIT_CS_HIGH: if (cs_s) state <= IDLE;
        IDLE:         if (cs_fall) state <= LOAD;
        LOAD: begin
          tx_shift <= CPHA ? tx_word : {tx_word[DATA_W-2:0], 1'b0};
          miso     <= !CPHA && tx_word[DATA_W-1];
          bit_cnt  <= '0;
          first    <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (sample_edge) begin
            rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
            if (word_done) begin
              bit_cnt  <= '0;
              first    <= 1'b0;
              tx_shift <= tx_word;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          if (shift_edge) begin
            miso     <= tx_shift[DATA_W-1];
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
        default: state <= WAIT_CS_HIGH;
      endcase
    end
  end

  assign o_spi_miso = miso;

`ifdef AXIS_SPI_STATUS_EN
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      o_rx_overflow_cnt <= '0;
      o_tx_underrun_cnt <= '0;
      o_frame_abort     <= 1'b0;
    end else begin
      o_frame_abort <= cs_rise && (state == SHIFT) && (bit_cnt != '0);
      if (word_done && rx_full && (o_rx_overflow_cnt != 8'hFF))
        o_rx_overflow_cnt <= o_rx_overflow_cnt + 8'd1;
      if (tx_load && tx_empty && (o_tx_underrun_cnt != 8'hFF))
        o_tx_underrun_cnt <= o_tx_underrun_cnt + 8'd1;
    end
  end
`endif

endmodule
